// File: rtl/vjtag_frame_parser.sv
// rtl/vjtag_frame_parser.sv - virtual-JTAG byte stream to checked 24-bit frame FIFO
module vjtag_frame_parser #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        tck,
    input  logic        aclr,
    input  logic        udr,
    input  logic [7:0]  byte_in,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic [23:0] frm_data,
    output logic [7:0]  chk_err_cnt,
    output logic [7:0]  drop_cnt,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, CHK} state_t;

    state_t      state;
    logic        udr_q;
    logic        ev;
    logic        cap_vld;
    logic [7:0]  cap_byte;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [23:0] mem [FIFO_DEPTH];
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        frame_done;
    logic        chk_match;

    assign ev = udr_q & ~udr;

    // Byte is taken one cycle after the udr fall so upstream data has settled
    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) begin
            udr_q    <= 1'b0;
            cap_vld  <= 1'b0;
            cap_byte <= 8'h00;
        end else begin
            udr_q   <= udr;
            cap_vld <= ev;
            if (ev) begin
                cap_byte <= byte_in;
            end
        end
    end

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign frm_valid  = ~empty;
    assign pop        = frm_valid & frm_ready;
    assign frame_done = cap_vld && (state == CHK);
    assign chk_match  = (cap_byte == (cmd ^ addr ^ data));
    // A pop in the same cycle frees a slot, so a full FIFO can still take the frame
    assign push       = frame_done && chk_match && (!full || pop);
    assign busy       = (state != IDLE);
    assign frm_data   = empty ? 24'h000000 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) begin
            state       <= IDLE;
            cmd         <= 8'h00;
            addr        <= 8'h00;
            data        <= 8'h00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            chk_err_cnt <= 8'h00;
            drop_cnt    <= 8'h00;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (cap_vld) begin
                case (state)
                    IDLE: begin
                        if (cap_byte == SYNC_BYTE) begin
                            state <= CMD;
                        end
                    end
                    CMD: begin
                        cmd   <= cap_byte;
                        state <= ADDR;
                    end
                    ADDR: begin
                        addr  <= cap_byte;
                        state <= DATA;
                    end
                    DATA: begin
                        data  <= cap_byte;
                        state <= CHK;
                    end
                    CHK: begin
                        state <= IDLE;
                        if (!chk_match) begin
                            if (chk_err_cnt != 8'hFF) begin
                                chk_err_cnt <= chk_err_cnt + 8'd1;
                            end
                        end else if (full && !pop) begin
                            if (drop_cnt != 8'hFF) begin
                                drop_cnt <= drop_cnt + 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge tck) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd, addr, data};
        end
    end
endmodule

// File: tb/tb_vjtag_frame_parser.sv
// tb/tb_vjtag_frame_parser.sv - randomized self-checking bench for vjtag_frame_parser
module tb_vjtag_frame_parser;
    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         DEPTH = 4;

    logic        tck = 1'b0;
    logic        aclr;
    logic        udr;
    logic [7:0]  byte_in;
    logic        frm_ready;
    logic        frm_valid;
    logic [23:0] frm_data;
    logic [7:0]  chk_err_cnt;
    logic [7:0]  drop_cnt;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference: bytes of the frame being collected, stored frames, counters
    logic [7:0]  pbuf [$];
    logic [23:0] mq [$];
    int          m_chk;
    int          m_drop;

    vjtag_frame_parser #(.SYNC_BYTE(SYNC), .FIFO_DEPTH(DEPTH)) dut (
        .tck(tck), .aclr(aclr), .udr(udr), .byte_in(byte_in),
        .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_data(frm_data),
        .chk_err_cnt(chk_err_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 tck = ~tck;

    task automatic model_byte(input logic [7:0] b, input bit popped);
        if (popped && mq.size() > 0) void'(mq.pop_front());
        if (pbuf.size() == 0 && b != SYNC) return;
        pbuf.push_back(b);
        if (pbuf.size() == 5) begin
            if (b == (pbuf[1] ^ pbuf[2] ^ pbuf[3])) begin
                if (mq.size() < DEPTH) mq.push_back({pbuf[1], pbuf[2], pbuf[3]});
                else if (m_drop < 255) m_drop++;
            end else if (m_chk < 255) begin
                m_chk++;
            end
            pbuf.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop);
        @(posedge tck); #1 udr = 1'b1; byte_in = b;
        @(posedge tck); #1 udr = 1'b0;
        @(posedge tck); #1;
        if (pop) frm_ready = 1'b1;
        @(posedge tck); #1 frm_ready = 1'b0;
        model_byte(b, pop && frm_valid);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                              input bit good, input bit pop_last);
        logic [7:0] k;
        k = good ? (c ^ a ^ d) : (c ^ a ^ d ^ 8'h5A);
        send_byte(SYNC, 1'b0);
        send_byte(c, 1'b0);
        send_byte(a, 1'b0);
        send_byte(d, 1'b0);
        send_byte(k, pop_last);
    endtask

    task automatic pop_one();
        frm_ready = 1'b1;
        @(posedge tck); #1 frm_ready = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic do_reset();
        aclr = 1'b1; udr = 1'b0; frm_ready = 1'b0; byte_in = 8'h00;
        @(posedge tck); #1 aclr = 1'b0;
        pbuf.delete(); mq.delete(); m_chk = 0; m_drop = 0;
    endtask

    task automatic test_reset();
        aclr = 1'b1; udr = 1'b0; frm_ready = 1'b0; byte_in = 8'h00;
        #12;
        n_cmp++; if (frm_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b expected 0", frm_valid); end
        n_cmp++; if (frm_data !== 24'h0) begin n_mis++; $display("FAIL reset_data: got %h expected 000000", frm_data); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (chk_err_cnt !== 8'h0) begin n_mis++; $display("FAIL reset_chk: got %h expected 00", chk_err_cnt); end
        n_cmp++; if (drop_cnt !== 8'h0) begin n_mis++; $display("FAIL reset_drop: got %h expected 00", drop_cnt); end
        // udr high through reset and low right after release must not create a byte event
        udr = 1'b1; byte_in = SYNC;
        @(posedge tck); #1 aclr = 1'b0; udr = 1'b0;
        repeat (4) @(posedge tck);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_no_ev: busy got %b expected 0", busy); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h03, 0);
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL basic_busy: got %b expected 1", busy); end
        n_cmp++; if (frm_valid !== 1'b0) begin n_mis++; $display("FAIL basic_early_valid: got %b expected 0", frm_valid); end
        send_byte(8'h33, 0);
        n_cmp++; if (frm_valid !== 1'b1) begin n_mis++; $display("FAIL basic_valid: got %b expected 1", frm_valid); end
        n_cmp++; if (frm_data !== 24'h102003) begin n_mis++; $display("FAIL basic_data: got %h expected 102003", frm_data); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL basic_idle: got %b expected 0", busy); end
        pop_one();
        n_cmp++; if (frm_valid !== 1'b0 || frm_data !== 24'h0) begin n_mis++; $display("FAIL basic_empty: got %b/%h expected 0/000000", frm_valid, frm_data); end
    endtask

    task automatic test_bad_chk();
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'hFF, 0);
        n_cmp++; if (chk_err_cnt !== 8'(m_chk) || m_chk != 1) begin n_mis++; $display("FAIL bad_chk_cnt: got %0d expected %0d", chk_err_cnt, m_chk); end
        n_cmp++; if (frm_valid !== 1'b0) begin n_mis++; $display("FAIL bad_chk_valid: got %b expected 0", frm_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL bad_chk_busy: got %b expected 0", busy); end
    endtask

    task automatic test_overflow();
        int k;
        do_reset();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 8'(8'h10 + i), 8'(8'h20 + i), 1'b1, 1'b0);
        n_cmp++; if (drop_cnt !== 8'(m_drop) || m_drop != 1) begin n_mis++; $display("FAIL ovf_drop: got %0d expected %0d", drop_cnt, m_drop); end
        k = 0;
        while (frm_valid === 1'b1 && k < 8) begin
            n_cmp++; if (mq.size() == 0 || frm_data !== mq[0]) begin n_mis++; $display("FAIL ovf_head%0d: got %h expected %h", k, frm_data, (mq.size() > 0) ? mq[0] : 24'h0); end
            pop_one(); k++;
        end
        n_cmp++; if (k != DEPTH) begin n_mis++; $display("FAIL ovf_count: got %0d expected %0d", k, DEPTH); end
    endtask

    task automatic test_push_pop_full();
        int k;
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h40 + i), 8'h55, 8'(i * 3), 1'b1, 1'b0);
        n_cmp++; if (frm_data !== mq[0]) begin n_mis++; $display("FAIL ppf_head: got %h expected %h", frm_data, mq[0]); end
        send_frame(8'h77, 8'h88, 8'h99, 1'b1, 1'b1);
        n_cmp++; if (drop_cnt !== 8'h00) begin n_mis++; $display("FAIL ppf_drop: got %0d expected 0", drop_cnt); end
        k = 0;
        while (frm_valid === 1'b1 && k < 8) begin
            n_cmp++; if (mq.size() == 0 || frm_data !== mq[0]) begin n_mis++; $display("FAIL ppf_entry%0d: got %h expected %h", k, frm_data, (mq.size() > 0) ? mq[0] : 24'h0); end
            pop_one(); k++;
        end
        n_cmp++; if (k != DEPTH) begin n_mis++; $display("FAIL ppf_count: got %0d expected %0d", k, DEPTH); end
    endtask

    task automatic test_push_pop_one();
        do_reset();
        send_frame(8'h11, 8'h22, 8'h44, 1'b1, 1'b0);
        send_frame(8'hC3, 8'h3C, 8'h0F, 1'b1, 1'b1);
        n_cmp++; if (frm_valid !== 1'b1 || frm_data !== mq[0] || mq.size() != 1) begin n_mis++; $display("FAIL ppo_head: got %b/%h expected 1/%h", frm_valid, frm_data, mq[0]); end
        pop_one();
        n_cmp++; if (frm_valid !== 1'b0) begin n_mis++; $display("FAIL ppo_empty: got %b expected 0", frm_valid); end
    endtask

    task automatic test_resync();
        do_reset();
        send_byte(8'h00, 0); send_byte(8'hA5, 0); send_byte(8'hA5, 0);
        send_byte(8'hB0, 0); send_byte(8'hC0, 0); send_byte(8'hD5, 0);
        n_cmp++; if (frm_valid !== 1'b1 || frm_data !== 24'hA5B0C0) begin n_mis++; $display("FAIL resync: got %b/%h expected 1/a5b0c0", frm_valid, frm_data); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_frame(8'h01, 8'h02, 8'h04, 1'b1, 1'b0);
        send_byte(8'hA5, 0); send_byte(8'h10, 0);
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL midrst_busy_pre: got %b expected 1", busy); end
        aclr = 1'b1; #2;
        n_cmp++; if (busy !== 1'b0 || frm_valid !== 1'b0 || frm_data !== 24'h0) begin n_mis++; $display("FAIL midrst_async: got %b/%b/%h expected 0/0/000000", busy, frm_valid, frm_data); end
        @(posedge tck); #1 aclr = 1'b0;
        pbuf.delete(); mq.delete(); m_chk = 0; m_drop = 0;
        send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h03, 0); send_byte(8'h33, 0);
        n_cmp++; if (frm_valid !== 1'b0 || busy !== 1'b0 || chk_err_cnt !== 8'h0) begin n_mis++; $display("FAIL midrst_ignored: got %b/%b/%h expected 0/0/00", frm_valid, busy, chk_err_cnt); end
        send_frame(8'h10, 8'h20, 8'h03, 1'b1, 1'b0);
        n_cmp++; if (frm_data !== 24'h102003) begin n_mis++; $display("FAIL midrst_frame: got %h expected 102003", frm_data); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    b = 8'($urandom);
                    if (b == SYNC) b = 8'h00;
                    send_byte(b, 0);
                end
                1: send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
                default: send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, $urandom_range(0, 1) == 1);
            endcase
            n_cmp++; if (chk_err_cnt !== 8'(m_chk) || drop_cnt !== 8'(m_drop)) begin n_mis++; $display("FAIL rnd_cnt%0d: got %0d/%0d expected %0d/%0d", it, chk_err_cnt, drop_cnt, m_chk, m_drop); end
            n_cmp++; if (frm_valid !== (mq.size() > 0) || busy !== (pbuf.size() > 0)) begin n_mis++; $display("FAIL rnd_flags%0d: got %b/%b expected %b/%b", it, frm_valid, busy, mq.size() > 0, pbuf.size() > 0); end
            for (int p = $urandom_range(0, 2); p > 0; p--) begin
                n_cmp++; if (frm_data !== ((mq.size() > 0) ? mq[0] : 24'h0)) begin n_mis++; $display("FAIL rnd_head%0d: got %h expected %h", it, frm_data, (mq.size() > 0) ? mq[0] : 24'h0); end
                pop_one();
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 260; i++) send_frame(8'(i), 8'h01, 8'h02, 1'b0, 1'b0);
        n_cmp++; if (chk_err_cnt !== 8'(m_chk) || m_chk != 255) begin n_mis++; $display("FAIL chk_sat: got %h expected %h", chk_err_cnt, 8'(m_chk)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_chk();
        test_overflow();
        test_push_pop_full();
        test_push_pop_one();
        test_resync();
        test_mid_reset();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
